// File: rtl/pifo_pkg.sv
// Shared types and rank compare for the register PIFO.
// Define PIFO_RANK_WRAP_EN for serial-number (wrapping) rank order.
package pifo_pkg;
  localparam int RANK_WIDTH = 16;
  localparam int META_WIDTH = 16;

  typedef struct packed {
    logic                  vld;
    logic [RANK_WIDTH-1:0] rank;
    logic [META_WIDTH-1:0] meta;
  } entry_t;

  function automatic logic rank_gt(
    input logic [RANK_WIDTH-1:0] a,
    input logic [RANK_WIDTH-1:0] b
  );
`ifdef PIFO_RANK_WRAP_EN
    logic [RANK_WIDTH-1:0] d;
    d = a - b;
    return (d != '0) && !d[RANK_WIDTH-1];
`else
    return a > b;
`endif
  endfunction
endpackage

// File: rtl/pifo_sorted_reg_if.sv
// Ingress pull / egress head bundle of the register PIFO.
// Master is the surrounding logic, slave is the PIFO.
interface pifo_sorted_reg_if #(
  parameter int RANK_WIDTH = 16,
  parameter int META_WIDTH = 16,
  parameter int CNT_WIDTH  = 5
);
  logic                  in_valid;
  logic [RANK_WIDTH-1:0] in_rank;
  logic [META_WIDTH-1:0] in_meta;
  logic                  in_pop;
  logic                  out_valid;
  logic [RANK_WIDTH-1:0] out_rank;
  logic [META_WIDTH-1:0] out_meta;
  logic                  out_pop;
  logic [CNT_WIDTH-1:0]  count;
  logic                  full;

  modport master (
    output in_valid, in_rank, in_meta, out_pop,
    input  in_pop, out_valid, out_rank, out_meta,
    input  count, full
  );

  modport slave (
    input  in_valid, in_rank, in_meta, out_pop,
    output in_pop, out_valid, out_rank, out_meta,
    output count, full
  );
endinterface

// File: rtl/pifo_cell.sv
// One PIFO slot: hold, shift toward head, shift toward tail, or load new.
// o_gt flags that the new entry belongs at or before this slot.
module pifo_cell
  import pifo_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_ins,
  input  logic   i_pop,
  input  logic   i_sel,
  input  logic   i_past,
  input  entry_t i_new,
  input  entry_t i_upper,
  input  entry_t i_lower,
  output entry_t o_ent,
  output logic   o_gt
);
  entry_t r_ent;
  entry_t w_nxt;

  assign o_ent = r_ent;
  assign o_gt  = !r_ent.vld
               || rank_gt(r_ent.rank, i_new.rank);

  // With a pop, "past" means this slot sits after the new entry
  // in the post-pop view and so keeps its current occupant.
  always_comb begin
    w_nxt = r_ent;
    unique case ({i_ins, i_pop})
      2'b10: begin
        if (i_sel)       w_nxt = i_new;
        else if (i_past) w_nxt = i_upper;
      end
      2'b11: begin
        if (i_sel)        w_nxt = i_new;
        else if (!i_past) w_nxt = i_lower;
      end
      2'b01:   w_nxt = i_lower;
      default: w_nxt = r_ent;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ent <= '0;
    else     r_ent <= w_nxt;
  end
endmodule

// File: rtl/pifo_sorted_reg.sv
// Register PIFO: DEPTH sorted slots, lowest rank presented at slot 0.
// Rank order is wrapping when PIFO_RANK_WRAP_EN is defined.
module pifo_sorted_reg
  import pifo_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int RANK_WIDTH = pifo_pkg::RANK_WIDTH,
  parameter int META_WIDTH = pifo_pkg::META_WIDTH,
  parameter int CNT_WIDTH  = 5
) (
  input logic               clk,
  input logic               rst,
  pifo_sorted_reg_if.slave  io_bus
);
  entry_t               w_ent [DEPTH+1];
  logic [DEPTH:0]       w_gt;
  logic [DEPTH-1:0]     w_sel;
  logic [DEPTH-1:0]     w_past;
  entry_t               w_new;
  logic                 w_pop;
  logic                 w_ins;
  logic                 w_full;
  logic [CNT_WIDTH-1:0] r_count;

  assign w_ent[DEPTH] = '0;
  assign w_gt[DEPTH]  = 1'b1;

  assign w_new.vld  = 1'b1;
  assign w_new.rank = io_bus.in_rank;
  assign w_new.meta = io_bus.in_meta;

  assign w_full = (r_count == CNT_WIDTH'(DEPTH));
  assign w_pop  = io_bus.out_pop & w_ent[0].vld;
  assign w_ins  = !rst & io_bus.in_valid
                & (!w_full | w_pop);

  // On pop the insertion point is found in the view shifted by one.
  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    if (i == 0) begin : g_head
      assign w_past[i] = 1'b0;
      assign w_sel[i]  = w_pop ? w_gt[1] : w_gt[0];
    end else begin : g_body
      assign w_past[i] = w_pop ? w_gt[i] : w_gt[i-1];
      assign w_sel[i]  = w_pop
                       ? (w_gt[i+1] & !w_gt[i])
                       : (w_gt[i] & !w_gt[i-1]);
    end

    pifo_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .i_ins   (w_ins),
      .i_pop   (w_pop),
      .i_sel   (w_sel[i]),
      .i_past  (w_past[i]),
      .i_new   (w_new),
      .i_upper (w_ent[(i == 0) ? 0 : i-1]),
      .i_lower (w_ent[i+1]),
      .o_ent   (w_ent[i]),
      .o_gt    (w_gt[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      unique case ({w_ins, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign io_bus.in_pop    = w_ins;
  assign io_bus.out_valid = w_ent[0].vld;
  assign io_bus.out_rank  = w_ent[0].rank;
  assign io_bus.out_meta  = w_ent[0].meta;
  assign io_bus.count     = r_count;
  assign io_bus.full      = w_full;
endmodule

// File: tb/tb_pifo_sorted_reg.sv
// Directed bench for pifo_sorted_reg: vector table plus fill,
// full-swap and mid-cycle reset sequences.
module tb_pifo_sorted_reg;
`ifdef PIFO_RANK_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef struct {
    logic        iv;
    logic [15:0] rk;
    logic [15:0] mt;
    logic        op;
    logic        e_ip;
    logic        e_ov;
    logic [15:0] e_rk;
    logic [15:0] e_mt;
    int          e_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  vec_t v[$];

  always #5 clk = ~clk;

  pifo_sorted_reg_if #(
    .RANK_WIDTH(16), .META_WIDTH(16), .CNT_WIDTH(5)
  ) bus ();

  pifo_sorted_reg #(
    .DEPTH(16), .RANK_WIDTH(16),
    .META_WIDTH(16), .CNT_WIDTH(5)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus.slave)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic iv, input logic [15:0] rk,
    input logic [15:0] mt, input logic op,
    input logic e_ip, input logic e_ov,
    input logic [15:0] e_rk, input logic [15:0] e_mt,
    input int e_cnt);
    vec_t r;
    r.iv = iv; r.rk = rk; r.mt = mt; r.op = op;
    r.e_ip = e_ip; r.e_ov = e_ov;
    r.e_rk = e_rk; r.e_mt = e_mt; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic drive(input logic iv, input logic [15:0] rk,
                       input logic [15:0] mt, input logic op);
    bus.in_valid = iv;
    bus.in_rank  = rk;
    bus.in_meta  = mt;
    bus.out_pop  = op;
  endtask

  initial begin
    logic [15:0] w1, w2;
    logic [15:0] exp_rk;
    w1 = WRAP ? 16'hFFFE : 16'h0001;
    w2 = WRAP ? 16'h0001 : 16'hFFFE;

    // 5/A 3/B 9/C 3/D then drain
    v.push_back(mk(1, 5, 16'hA, 0, 1, 0, 0, 0, 0));
    v.push_back(mk(1, 3, 16'hB, 0, 1, 1, 5, 16'hA, 1));
    v.push_back(mk(1, 9, 16'hC, 0, 1, 1, 3, 16'hB, 2));
    v.push_back(mk(1, 3, 16'hD, 0, 1, 1, 3, 16'hB, 3));
    v.push_back(mk(0, 0, 0, 1, 0, 1, 3, 16'hB, 4));
    v.push_back(mk(0, 0, 0, 1, 0, 1, 3, 16'hD, 3));
    v.push_back(mk(0, 0, 0, 1, 0, 1, 5, 16'hA, 2));
    v.push_back(mk(0, 0, 0, 1, 0, 1, 9, 16'hC, 1));
    v.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    // 4,8 then pop + insert 6
    v.push_back(mk(1, 4, 16'h44, 0, 1, 0, 0, 0, 0));
    v.push_back(mk(1, 8, 16'h88, 0, 1, 1, 4, 16'h44, 1));
    v.push_back(mk(1, 6, 16'h66, 1, 1, 1, 4, 16'h44, 2));
    v.push_back(mk(0, 0, 0, 1, 0, 1, 6, 16'h66, 2));
    v.push_back(mk(0, 0, 0, 1, 0, 1, 8, 16'h88, 1));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    // 7,9 then pop + insert 1 becomes head
    v.push_back(mk(1, 7, 16'h77, 0, 1, 0, 0, 0, 0));
    v.push_back(mk(1, 9, 16'h99, 0, 1, 1, 7, 16'h77, 1));
    v.push_back(mk(1, 1, 16'h11, 1, 1, 1, 7, 16'h77, 2));
    v.push_back(mk(0, 0, 0, 1, 0, 1, 1, 16'h11, 2));
    v.push_back(mk(0, 0, 0, 1, 0, 1, 9, 16'h99, 1));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    // rank wrap ordering
    v.push_back(mk(1, 16'hFFFE, 16'h1, 0, 1, 0, 0, 0, 0));
    v.push_back(mk(1, 16'h0001, 16'h2, 0, 1, 1, 16'hFFFE, 16'h1, 1));
    v.push_back(mk(0, 0, 0, 0, 0, 1, w1, WRAP ? 16'h1 : 16'h2, 2));
    v.push_back(mk(0, 0, 0, 1, 0, 1, w1, WRAP ? 16'h1 : 16'h2, 2));
    v.push_back(mk(0, 0, 0, 1, 0, 1, w2, WRAP ? 16'h2 : 16'h1, 1));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    // reset state, with an offered entry that must not be pulled
    drive(1, 16'h0, 16'h0, 1);
    #2;
    chk("rst_ov",    32'(bus.out_valid), 0);
    chk("rst_cnt",   32'(bus.count), 0);
    chk("rst_inpop", 32'(bus.in_pop), 0);
    chk("rst_full",  32'(bus.full), 0);
    chk("rst_rank",  32'(bus.out_rank), 0);
    chk("rst_meta",  32'(bus.out_meta), 0);
    @(negedge clk);
    drive(0, 0, 0, 0);
    #1 rst = 1'b0;

    foreach (v[i]) begin
      @(negedge clk);
      drive(v[i].iv, v[i].rk, v[i].mt, v[i].op);
      #1;
      chk($sformatf("v%0d_inpop", i), 32'(bus.in_pop), 32'(v[i].e_ip));
      chk($sformatf("v%0d_ov", i), 32'(bus.out_valid), 32'(v[i].e_ov));
      chk($sformatf("v%0d_cnt", i), 32'(bus.count), 32'(v[i].e_cnt));
      if (v[i].e_ov) begin
        chk($sformatf("v%0d_rank", i), 32'(bus.out_rank), 32'(v[i].e_rk));
        chk($sformatf("v%0d_meta", i), 32'(bus.out_meta), 32'(v[i].e_mt));
      end
    end

    // fill 16 with descending ranks 32,30..2
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(1, 16'((16 - i) * 2), 16'(i), 0);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1, 16'd1, 16'hBB, 0);
      #1;
      chk("full_inpop", 32'(bus.in_pop), 0);
      chk("full_flag",  32'(bus.full), 1);
      chk("full_cnt",   32'(bus.count), 16);
      chk("full_head",  32'(bus.out_rank), 2);
      chk("full_meta",  32'(bus.out_meta), 15);
    end
    @(negedge clk);
    drive(1, 16'd0, 16'hAA, 1);
    #1;
    chk("swap_inpop", 32'(bus.in_pop), 1);
    @(negedge clk);
    drive(0, 0, 0, 0);
    #1;
    chk("swap_head", 32'(bus.out_rank), 0);
    chk("swap_meta", 32'(bus.out_meta), 16'hAA);
    chk("swap_cnt",  32'(bus.count), 16);
    chk("swap_full", 32'(bus.full), 1);
    for (int k = 0; k < 16; k++) begin
      exp_rk = (k == 0) ? 16'd0 : 16'(2 * (k + 1));
      @(negedge clk);
      drive(0, 0, 0, 1);
      #1;
      chk($sformatf("drain%0d", k), 32'(bus.out_rank), 32'(exp_rk));
    end
    @(negedge clk);
    drive(0, 0, 0, 0);
    #1;
    chk("drain_cnt", 32'(bus.count), 0);
    chk("drain_ov",  32'(bus.out_valid), 0);

    // 7 entries, then reset asserted between edges
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(1, 16'(10 + i), 16'(i), 0);
    end
    @(negedge clk);
    drive(1, 16'd50, 16'h5, 0);
    #1;
    chk("pre_rst_cnt", 32'(bus.count), 7);
    rst = 1'b1;
    #1;
    chk("arst_ov",    32'(bus.out_valid), 0);
    chk("arst_cnt",   32'(bus.count), 0);
    chk("arst_inpop", 32'(bus.in_pop), 0);
    drive(0, 0, 0, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    drive(1, 16'd2, 16'h22, 0);
    @(negedge clk);
    drive(0, 0, 0, 0);
    #1;
    chk("post_rst_ov",   32'(bus.out_valid), 1);
    chk("post_rst_head", 32'(bus.out_rank), 2);
    chk("post_rst_meta", 32'(bus.out_meta), 16'h22);
    chk("post_rst_cnt",  32'(bus.count), 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
